mem_req_arbiter: RTL and testbench
==================================

# mem_req_arbiter

Two-master, one-slave arbiter for the CPU's single sram-like memory port. It sits between the fetch stage (instruction master) and the EX/MEM stages (data master) on one side and the shared memory interface on the other. It accepts one transaction at a time, drives it to the slave and returns the response to the owning master. It also enforces a starvation guard so that back-to-back loads and stores cannot block instruction fetch indefinitely.

## Interface
- Parameters:
- STARVE_MAX, default 4: consecutive lost arbitrations by the instruction master before it is forced to win.
- Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- inst_req / data_req  in  1  master request, held until the matching addr_ok.
- inst_wr / data_wr  in  1  1 = write.
- inst_size / data_size  in  2  0 = byte, 1 = half, 2 = word.
- inst_addr / data_addr  in  32  byte address.
- inst_wstrb / data_wstrb  in  4  byte enables for writes.
- inst_wdata / data_wdata  in  32  write data.
- inst_addr_ok / data_addr_ok  out  1  request accepted (1-cycle pulse).
- inst_data_ok / data_data_ok  out  1  response valid (1-cycle pulse).
- inst_rdata / data_rdata  out  32  read data; 0 when the matching data_ok is low.
- mem_req  out  1  slave request, held until mem_addr_ok.
- mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata  out  1/2/32/4/32  latched copy of the winning request.
- mem_addr_ok  in  1  slave accepted the request.
- mem_data_ok  in  1  slave response valid.
- mem_rdata  in  32  slave read data.

## Operation
- FSM states: IDLE, ADDR, DATA.
- Owner register: `owner` (0 = inst, 1 = data).
- Starvation counter: `starve` (3 bits), saturating at STARVE_MAX.
- IDLE:
  - Arbitrate whenever either request is high.
  - Data wins, unless inst_req=1 and starve==STARVE_MAX; in that case inst wins.
  - The winner's addr_ok is asserted combinationally in the same cycle.
  - Its wr/size/addr/wstrb/wdata are latched into the mem_* registers, and owner is set.
  - Next state is ADDR.
  - The loser's addr_ok stays 0, and the loser must hold its request.
- Starvation counter rules:
  - starve increments (saturating) when data wins while inst_req=1.
  - starve clears to 0 whenever inst wins.
  - Otherwise starve is unchanged.
- ADDR:
  - mem_req=1 with the latched fields.
  - When mem_addr_ok=1, go to DATA (mem_req drops next cycle).
- DATA:
  - mem_req=0.
  - When mem_data_ok=1, pulse the owner's data_ok and route mem_rdata to the owner's rdata; next state is IDLE.
  - The non-owner's data_ok and rdata stay 0.
- Stray inputs:
  - mem_data_ok in IDLE or ADDR is ignored.
  - mem_addr_ok in IDLE or DATA is ignored.
- Masters in ADDR/DATA: requests are not accepted and no addr_ok is issued; requesters simply stay pending.
- Writes follow the same flow: masters must wait for data_ok even on writes.
- Size/strobe: passed through unchanged; no alignment checks.

## Timing
- Reset (resetn=0, asynchronous):
  - state=IDLE, owner=0, starve=0, all mem_* outputs=0.
  - All master outputs are forced to 0 while resetn=0, including combinational addr_ok.
- Reset mid-transaction abandons the transaction; a late mem_data_ok after release is ignored because the state is IDLE.
- Minimum transaction, with master req at cycle N:
  - addr_ok at N.
  - mem_req at N+1.
  - With mem_addr_ok at N+1, mem_data_ok can be taken at N+2 earliest, giving master data_ok at N+2.
  - Next acceptance at N+3.
- Throughput: at most one transaction per 3 cycles; one outstanding transaction only.
- Simultaneous events: inst_req and data_req in the same IDLE cycle resolve in that cycle per the priority and starvation rules; the loser is accepted in the first IDLE cycle after the current transaction.
- mem_* outputs are stable from ADDR entry until the next IDLE acceptance.

## Test plan
- Single read: data_req with addr=0x100; slave acks addr_ok after 2 wait cycles and data_ok 1 cycle later with rdata=0xDEADBEEF.
  - Required: data_addr_ok at cycle 0; mem_req high cycles 1-3; data_data_ok with data_rdata=0xDEADBEEF; inst outputs stay 0.
- Collision: inst_req and data_req both held from cycle 0.
  - Required: data wins first (mem_addr=data_addr); inst is accepted in the IDLE cycle after the data response; starve goes 1 then 0.
- Starvation: data_req and inst_req held continuously, STARVE_MAX=4.
  - Required: data wins 4 transactions, the 5th goes to inst, then data wins again; the pattern repeats.
- Write: data_wr=1, wstrb=0011, wdata=0x12345678, size=1.
  - Required: the mem_* fields match exactly; data_data_ok follows mem_data_ok; data_rdata=0.
- Stray handshakes: mem_data_ok pulsed in IDLE, and mem_addr_ok pulsed in DATA.
  - Required: no master data_ok and no state change.
- Async reset during DATA.
  - Required: all outputs 0 immediately; after release, a fresh inst_req is accepted in its first cycle and a late mem_data_ok is ignored.

Source files
------------

// File: rtl/mem_req_arbiter_if.sv
// One sram-like request/response channel. The arbiter uses the slave view for
// each CPU master and the master view toward the shared memory port.
interface mem_req_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (output req, wr, size, addr, wstrb, wdata,
                  input  addr_ok, data_ok, rdata);
  modport slave  (input  req, wr, size, addr, wstrb, wdata,
                  output addr_ok, data_ok, rdata);
endinterface

// File: rtl/mem_req_arbiter.sv
// Two-master (inst/data) to one-slave sram-like arbiter, one transaction in
// flight, data priority with a starvation guard that forces an inst grant.
module mem_req_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              resetn,
  mem_req_arbiter_if.slave  inst,
  mem_req_arbiter_if.slave  data,
  mem_req_arbiter_if.master mem
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  localparam logic [2:0] SMAX = 3'(STARVE_MAX);

  state_t     state;
  logic       owner;
  logic [2:0] starve;
  logic       inst_win, data_win, done;

  // Grants and responses are gated by resetn so masters see zeros during reset.
  always_comb begin
    inst_win = resetn && (state == IDLE) && inst.req && (!data.req || starve == SMAX);
    data_win = resetn && (state == IDLE) && data.req && !inst_win;
    done     = resetn && (state == DATA) && mem.data_ok;
  end

  assign inst.addr_ok = inst_win;
  assign data.addr_ok = data_win;
  assign inst.data_ok = done && !owner;
  assign data.data_ok = done && owner;
  assign inst.rdata   = (done && !owner) ? mem.rdata : '0;
  assign data.rdata   = (done &&  owner) ? mem.rdata : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      owner     <= 1'b0;
      starve    <= '0;
      mem.req   <= 1'b0;
      mem.wr    <= 1'b0;
      mem.size  <= '0;
      mem.addr  <= '0;
      mem.wstrb <= '0;
      mem.wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (inst_win || data_win) begin
            state     <= ADDR;
            mem.req   <= 1'b1;
            owner     <= data_win;
            mem.wr    <= data_win ? data.wr    : inst.wr;
            mem.size  <= data_win ? data.size  : inst.size;
            mem.addr  <= data_win ? data.addr  : inst.addr;
            mem.wstrb <= data_win ? data.wstrb : inst.wstrb;
            mem.wdata <= data_win ? data.wdata : inst.wdata;
            if (inst_win)
              starve <= '0;
            else if (inst.req && starve != SMAX)
              starve <= starve + 3'd1;
          end
        end
        ADDR: begin
          if (mem.addr_ok) begin
            state   <= DATA;
            mem.req <= 1'b0;
          end
        end
        DATA: begin
          if (mem.data_ok) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed protocol scenarios followed by randomized traffic checked against a
// transaction-level model of the arbiter.
module tb_mem_req_arbiter;
  logic clk = 1'b0;
  logic resetn;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  mem_req_arbiter_if inst_if ();
  mem_req_arbiter_if data_if ();
  mem_req_arbiter_if mem_if ();

  mem_req_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .resetn(resetn), .inst(inst_if), .data(data_if), .mem(mem_if)
  );

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } fld_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inst(input fld_t f);
    inst_if.wr = f.wr; inst_if.size = f.size; inst_if.addr = f.addr;
    inst_if.wstrb = f.wstrb; inst_if.wdata = f.wdata;
  endtask

  task automatic set_data(input fld_t f);
    data_if.wr = f.wr; data_if.size = f.size; data_if.addr = f.addr;
    data_if.wstrb = f.wstrb; data_if.wdata = f.wdata;
  endtask

  function automatic fld_t rnd_fld();
    fld_t f;
    f.wr    = 1'($urandom_range(0, 1));
    f.size  = 2'($urandom_range(0, 2));
    f.addr  = $urandom;
    f.wstrb = 4'($urandom);
    f.wdata = $urandom;
    return f;
  endfunction

  function automatic fld_t rd_fld(input logic [31:0] a);
    fld_t f;
    f = '0;
    f.size = 2'd2;
    f.addr = a;
    return f;
  endfunction

  function automatic logic [31:0] pk(input fld_t f);
    return {25'd0, f.wr, f.size, f.wstrb};
  endfunction

  // transaction-level reference model state
  fld_t ireq_f, dreq_f, cur;
  logic cur_own;
  bit   outstanding, issued, drop_i, drop_d;
  int   losses;

  initial begin
    logic exp_iw, exp_dw, resp;
    fld_t wf;

    resetn = 1'b0;
    inst_if.req = 1'b0; data_if.req = 1'b0;
    set_inst('0); set_data('0);
    mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b0; mem_if.rdata = '0;

    // reset: grants forced low even with requests present
    tick();
    inst_if.req = 1'b1; data_if.req = 1'b1;
    #1;
    check("rst_iack", inst_if.addr_ok, 0);
    check("rst_dack", data_if.addr_ok, 0);
    check("rst_mreq", mem_if.req, 0);
    check("rst_maddr", mem_if.addr, 0);
    check("rst_starve", dut.starve, 0);
    inst_if.req = 1'b0; data_if.req = 1'b0;
    tick();
    resetn = 1'b1;

    // single read with two address wait cycles
    tick();
    data_if.req = 1'b1; set_data(rd_fld(32'h100));
    #1;
    check("rd_dack", data_if.addr_ok, 1);
    check("rd_iack", inst_if.addr_ok, 0);
    tick(); data_if.req = 1'b0; #1;
    check("rd_mreq1", mem_if.req, 1);
    check("rd_maddr", mem_if.addr, 32'h100);
    tick(); #1;
    check("rd_mreq2", mem_if.req, 1);
    tick(); mem_if.addr_ok = 1'b1; #1;
    check("rd_mreq3", mem_if.req, 1);
    check("rd_dok_early", data_if.data_ok, 0);
    tick(); mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b1; mem_if.rdata = 32'hDEADBEEF; #1;
    check("rd_mreq4", mem_if.req, 0);
    check("rd_dok", data_if.data_ok, 1);
    check("rd_rdata", data_if.rdata, 32'hDEADBEEF);
    check("rd_iok", inst_if.data_ok, 0);
    check("rd_irdata", inst_if.rdata, 0);

    // collision: data first, then inst in the next IDLE cycle
    tick(); mem_if.data_ok = 1'b0;
    inst_if.req = 1'b1; set_inst(rd_fld(32'h200));
    data_if.req = 1'b1; set_data(rd_fld(32'h300));
    #1;
    check("col_dack", data_if.addr_ok, 1);
    check("col_iack", inst_if.addr_ok, 0);
    tick(); data_if.req = 1'b0; mem_if.addr_ok = 1'b1; #1;
    check("col_maddr_d", mem_if.addr, 32'h300);
    check("col_starve1", dut.starve, 1);
    check("col_iack_busy", inst_if.addr_ok, 0);
    tick(); mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b1; mem_if.rdata = 32'h11; #1;
    check("col_dok", data_if.data_ok, 1);
    tick(); mem_if.data_ok = 1'b0; #1;
    check("col_iack2", inst_if.addr_ok, 1);
    tick(); inst_if.req = 1'b0; mem_if.addr_ok = 1'b1; #1;
    check("col_maddr_i", mem_if.addr, 32'h200);
    check("col_starve0", dut.starve, 0);
    tick(); mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b1; mem_if.rdata = 32'h22; #1;
    check("col_iok", inst_if.data_ok, 1);
    check("col_irdata", inst_if.rdata, 32'h22);

    // starvation: both held, every fifth grant goes to inst
    inst_if.req = 1'b1; set_inst(rd_fld(32'h400));
    data_if.req = 1'b1; set_data(rd_fld(32'h500));
    for (int t = 0; t < 10; t++) begin
      tick(); mem_if.data_ok = 1'b0; #1;
      check("stv_iack", inst_if.addr_ok, 32'(t % 5 == 4));
      check("stv_dack", data_if.addr_ok, 32'(t % 5 != 4));
      tick(); mem_if.addr_ok = 1'b1; #1;
      check("stv_maddr", mem_if.addr, (t % 5 == 4) ? 32'h400 : 32'h500);
      tick(); mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b1; mem_if.rdata = 32'(t); #1;
      check("stv_iok", inst_if.data_ok, 32'(t % 5 == 4));
    end

    // write passes fields through unchanged
    tick(); mem_if.data_ok = 1'b0; inst_if.req = 1'b0;
    wf.wr = 1'b1; wf.size = 2'd1; wf.addr = 32'h600; wf.wstrb = 4'b0011; wf.wdata = 32'h12345678;
    set_data(wf);
    #1;
    check("wr_dack", data_if.addr_ok, 1);
    tick(); data_if.req = 1'b0; mem_if.addr_ok = 1'b1; #1;
    check("wr_ctl", pk({mem_if.wr, mem_if.size, mem_if.addr, mem_if.wstrb, mem_if.wdata}), pk(wf));
    check("wr_addr", mem_if.addr, 32'h600);
    check("wr_wdata", mem_if.wdata, 32'h12345678);
    tick(); mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b1; mem_if.rdata = '0; #1;
    check("wr_dok", data_if.data_ok, 1);
    check("wr_rdata", data_if.rdata, 0);

    // stray handshakes: data_ok in IDLE, addr_ok in DATA
    tick(); #1;
    check("str_idle_iok", inst_if.data_ok, 0);
    check("str_idle_dok", data_if.data_ok, 0);
    tick(); mem_if.data_ok = 1'b0; inst_if.req = 1'b1; set_inst(rd_fld(32'h700)); #1;
    check("str_iack", inst_if.addr_ok, 1);
    tick(); inst_if.req = 1'b0; mem_if.addr_ok = 1'b1; #1;
    check("str_mreq", mem_if.req, 1);
    tick(); mem_if.addr_ok = 1'b0; #1;
    check("str_mreq_data", mem_if.req, 0);
    tick(); mem_if.addr_ok = 1'b1; #1;
    check("str_data_mreq", mem_if.req, 0);
    check("str_data_iok", inst_if.data_ok, 0);
    tick(); mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b1; mem_if.rdata = 32'h77; #1;
    check("str_mreq_after", mem_if.req, 0);
    check("str_iok", inst_if.data_ok, 1);
    check("str_irdata", inst_if.rdata, 32'h77);

    // asynchronous reset while waiting for data
    tick(); mem_if.data_ok = 1'b0; data_if.req = 1'b1; set_data(rd_fld(32'h800)); #1;
    check("ar_dack", data_if.addr_ok, 1);
    tick(); data_if.req = 1'b0; mem_if.addr_ok = 1'b1;
    tick(); mem_if.addr_ok = 1'b0;
    #1;
    inst_if.req = 1'b1; set_inst(rd_fld(32'h900));
    mem_if.data_ok = 1'b1; mem_if.rdata = 32'h5A5A5A5A;
    resetn = 1'b0;
    #1;
    check("ar_dok", data_if.data_ok, 0);
    check("ar_drdata", data_if.rdata, 0);
    check("ar_iack", inst_if.addr_ok, 0);
    check("ar_mreq", mem_if.req, 0);
    check("ar_maddr", mem_if.addr, 0);
    tick(); resetn = 1'b1; #1;
    check("ar_rel_iack", inst_if.addr_ok, 1);
    check("ar_rel_iok", inst_if.data_ok, 0);
    check("ar_rel_dok", data_if.data_ok, 0);
    tick(); inst_if.req = 1'b0; mem_if.data_ok = 1'b0; mem_if.addr_ok = 1'b1; #1;
    check("ar_maddr2", mem_if.addr, 32'h900);
    tick(); mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b1; mem_if.rdata = 32'h33; #1;
    check("ar_iok", inst_if.data_ok, 1);

    // randomized traffic against the transaction model, from a clean reset
    tick();
    mem_if.data_ok = 1'b0; inst_if.req = 1'b0; data_if.req = 1'b0;
    resetn = 1'b0;
    tick(); resetn = 1'b1;
    outstanding = 0; issued = 0; losses = 0; drop_i = 0; drop_d = 0;
    cur = '0; cur_own = 1'b0;
    for (int c = 0; c < 600; c++) begin
      tick();
      if (drop_i) inst_if.req = 1'b0;
      if (drop_d) data_if.req = 1'b0;
      if (!inst_if.req && $urandom_range(0, 3) != 0) begin
        ireq_f = rnd_fld(); set_inst(ireq_f); inst_if.req = 1'b1;
      end
      if (!data_if.req && $urandom_range(0, 3) != 0) begin
        dreq_f = rnd_fld(); set_data(dreq_f); data_if.req = 1'b1;
      end
      mem_if.addr_ok = 1'($urandom_range(0, 1));
      mem_if.data_ok = 1'($urandom_range(0, 1));
      mem_if.rdata   = $urandom;
      #1;
      exp_iw = !outstanding && inst_if.req && (!data_if.req || losses >= 4);
      exp_dw = !outstanding && data_if.req && !exp_iw;
      resp   = outstanding && issued && mem_if.data_ok;
      check("rnd_iack", inst_if.addr_ok, 32'(exp_iw));
      check("rnd_dack", data_if.addr_ok, 32'(exp_dw));
      check("rnd_mreq", mem_if.req, 32'(outstanding && !issued));
      check("rnd_iok", inst_if.data_ok, 32'(resp && !cur_own));
      check("rnd_dok", data_if.data_ok, 32'(resp && cur_own));
      check("rnd_irdata", inst_if.rdata, (resp && !cur_own) ? mem_if.rdata : 32'h0);
      check("rnd_drdata", data_if.rdata, (resp && cur_own) ? mem_if.rdata : 32'h0);
      if (outstanding) begin
        check("rnd_mctl", {25'd0, mem_if.wr, mem_if.size, mem_if.wstrb}, pk(cur));
        check("rnd_maddr", mem_if.addr, cur.addr);
        check("rnd_mwdata", mem_if.wdata, cur.wdata);
      end
      drop_i = exp_iw;
      drop_d = exp_dw;
      if (resp) outstanding = 0;
      else if (outstanding && !issued && mem_if.addr_ok) issued = 1;
      if (exp_iw || exp_dw) begin
        outstanding = 1; issued = 0;
        cur_own = exp_dw;
        cur = exp_dw ? dreq_f : ireq_f;
        if (exp_iw) losses = 0;
        else if (inst_if.req && losses < 4) losses++;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
